imm_extend_pipe: RTL and testbench

//  Pipelined, parametrised immediate-generation unit for the decode stage.
//  - Supersedes the single-mode combinational rotate/extend.
//  - Supports four immediate formats and produces the shifter carry-out.
//  - Two register stages with valid/ready flow control, so decode can stall
//    or flush without losing immediates.

---
 rtl/imm_extend_pipe_if.sv | 40 ++++
 rtl/imm_extend_pipe.sv | 106 ++++++++++
 tb/tb_imm_extend_pipe.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/imm_extend_pipe_if.sv
// Request/response bundle for the pipelined immediate generator.
// master = decode-side driver, slave = the immediate unit.
interface imm_extend_pipe_if #(
    parameter int DATA_W  = 32,
    parameter int INSTR_W = 24
);
    logic               in_valid;
    logic               in_ready;
    logic [1:0]         ImmSrc;
    logic [INSTR_W-1:0] Instr;
    logic               carry_in;
    logic               out_valid;
    logic               out_ready;
    logic [DATA_W-1:0]  ExtImm;
    logic               out_carry;

    modport master (
        output in_valid,
        output ImmSrc,
        output Instr,
        output carry_in,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  ExtImm,
        input  out_carry
    );

    modport slave (
        input  in_valid,
        input  ImmSrc,
        input  Instr,
        input  carry_in,
        input  out_ready,
        output in_ready,
        output out_valid,
        output ExtImm,
        output out_carry
    );
endinterface

// File: rtl/imm_extend_pipe.sv
// Two-stage immediate generator: rot8 / zext12 / branch24 / sext12
// with shifter carry-out and valid/ready flow control plus flush.
module imm_extend_pipe #(
    parameter int DATA_W  = 32,
    parameter int INSTR_W = 24
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    imm_extend_pipe_if.slave bus
);
    logic               w_adv1;
    logic               w_adv2;

    logic               r_s1_valid;
    logic [1:0]         r_s1_src;
    logic [INSTR_W-1:0] r_s1_instr;
    logic               r_s1_carry;

    logic               r_s2_valid;
    logic [DATA_W-1:0]  r_ext;
    logic               r_carry;

    logic [4:0]          w_rot;
    logic [DATA_W-1:0]   w_val8;
    logic [2*DATA_W-1:0] w_dbl;
    logic [DATA_W-1:0]   w_ext_nxt;
    logic                w_carry_nxt;

    assign w_adv2 = !r_s2_valid || bus.out_ready;
    assign w_adv1 = !r_s1_valid || w_adv2;

    assign bus.in_ready  = w_adv1;
    assign bus.out_valid = r_s2_valid;
    assign bus.ExtImm    = r_ext;
    assign bus.out_carry = r_carry;

    // Rotate right by doubling the word; low half is the rotated value.
    assign w_rot  = {r_s1_instr[11:8], 1'b0};
    assign w_val8 = {{(DATA_W-8){1'b0}}, r_s1_instr[7:0]};
    assign w_dbl  = {w_val8, w_val8} >> w_rot;

    always_comb begin
        w_ext_nxt   = '0;
        w_carry_nxt = r_s1_carry;
        unique case (r_s1_src)
            2'b00: begin
                w_ext_nxt = w_dbl[DATA_W-1:0];
                if (w_rot != 5'd0)
                    w_carry_nxt = w_dbl[DATA_W-1];
            end
            2'b01: begin
                w_ext_nxt = {{(DATA_W-12){1'b0}},
                             r_s1_instr[11:0]};
            end
            2'b10: begin
                w_ext_nxt = {{(DATA_W-INSTR_W-2){r_s1_instr[INSTR_W-1]}},
                             r_s1_instr, 2'b00};
            end
            2'b11: begin
                w_ext_nxt = {{(DATA_W-12){r_s1_instr[11]}},
                             r_s1_instr[11:0]};
            end
            default: begin
                w_ext_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s1_valid <= 1'b0;
            r_s1_src   <= '0;
            r_s1_instr <= '0;
            r_s1_carry <= 1'b0;
        end else begin
            if (flush)
                r_s1_valid <= 1'b0;
            else if (w_adv1)
                r_s1_valid <= bus.in_valid;
            if (w_adv1 && bus.in_valid) begin
                r_s1_src   <= bus.ImmSrc;
                r_s1_instr <= bus.Instr;
                r_s1_carry <= bus.carry_in;
            end
        end
    end

    // Result register only loads on advance, so a stalled output holds.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s2_valid <= 1'b0;
            r_ext      <= '0;
            r_carry    <= 1'b0;
        end else begin
            if (flush)
                r_s2_valid <= 1'b0;
            else if (w_adv2)
                r_s2_valid <= r_s1_valid;
            if (w_adv2 && r_s1_valid) begin
                r_ext   <= w_ext_nxt;
                r_carry <= w_carry_nxt;
            end
        end
    end
endmodule

// File: tb/tb_imm_extend_pipe.sv
// Directed self-checking bench for imm_extend_pipe (DATA_W=32, INSTR_W=24).
// Inputs driven and outputs sampled around the falling edge.
module tb_imm_extend_pipe;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic flush = 1'b0;
    int   checks = 0;
    int   failures = 0;

    imm_extend_pipe_if #(.DATA_W(32), .INSTR_W(24)) bus ();

    imm_extend_pipe #(.DATA_W(32), .INSTR_W(24)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .flush   (flush),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic [1:0] s, input logic [23:0] ins,
                         input logic c);
        bus.in_valid = 1'b1;
        bus.ImmSrc   = s;
        bus.Instr    = ins;
        bus.carry_in = c;
    endtask

    task automatic test_reset();
        bus.in_valid  = 1'b0;
        bus.ImmSrc    = 2'b00;
        bus.Instr     = '0;
        bus.carry_in  = 1'b0;
        bus.out_ready = 1'b1;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.ExtImm !== 32'h0 || bus.out_carry !== 1'b0)
            $display("FAIL reset_outputs: got v=%b imm=%h c=%b want v=0 imm=0 c=0",
                     bus.out_valid, bus.ExtImm, bus.out_carry);
        if (bus.out_valid !== 1'b0 || bus.ExtImm !== 32'h0 || bus.out_carry !== 1'b0)
            failures++;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_release: got rdy=%b v=%b want rdy=1 v=0",
                     bus.in_ready, bus.out_valid);
        end
    endtask

    task automatic test_formats();
        logic [1:0]  src [11] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0,
                                 2'd2, 2'd2, 2'd3, 2'd3, 2'd1, 2'd1};
        logic [23:0] ins [11] = '{24'h0004FF, 24'h0000AB, 24'h0000AB,
                                 24'h000101, 24'h123F12, 24'hFFFFFE,
                                 24'h000010, 24'h000800, 24'hABC7FF,
                                 24'hABC800, 24'h000800};
        logic        cin [11] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0,
                                 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [31:0] exp [11] = '{32'hFF000000, 32'h000000AB, 32'h000000AB,
                                 32'h40000000, 32'h00000048, 32'hFFFFFFF8,
                                 32'h00000040, 32'hFFFFF800, 32'h000007FF,
                                 32'h00000800, 32'h00000800};
        logic        ec  [11] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
                                 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        bus.out_ready = 1'b1;
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            drive(src[i], ins[i], cin[i]);
            #1;
            checks++;
            if (bus.in_ready !== 1'b1) begin
                failures++;
                $display("FAIL fmt%0d_in_ready: got %b want 1", i, bus.in_ready);
            end
            @(negedge clk);
            bus.in_valid = 1'b0;
            #1;
            checks++;
            if (bus.out_valid !== 1'b0) begin
                failures++;
                $display("FAIL fmt%0d_early: out_valid got %b want 0", i, bus.out_valid);
            end
            @(negedge clk);
            #1;
            checks++;
            if (bus.out_valid !== 1'b1 || bus.ExtImm !== exp[i] || bus.out_carry !== ec[i]) begin
                failures++;
                $display("FAIL fmt%0d_result: got v=%b imm=%h c=%b want v=1 imm=%h c=%b",
                         i, bus.out_valid, bus.ExtImm, bus.out_carry, exp[i], ec[i]);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [1:0]  src [3] = '{2'd1, 2'd1, 2'd1};
        logic [23:0] ins [3] = '{24'h000011, 24'h000022, 24'h000033};
        logic [31:0] exp [3] = '{32'h11, 32'h22, 32'h33};
        bus.out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (c < 3) drive(src[c], ins[c], 1'b0);
            else bus.in_valid = 1'b0;
            #1;
            if (c >= 2) begin
                checks++;
                if (bus.out_valid !== 1'b1 || bus.ExtImm !== exp[c-2]) begin
                    failures++;
                    $display("FAIL b2b_%0d: got v=%b imm=%h want v=1 imm=%h",
                             c-2, bus.out_valid, bus.ExtImm, exp[c-2]);
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        logic [1:0]  src [4] = '{2'd1, 2'd3, 2'd0, 2'd2};
        logic [23:0] ins [4] = '{24'h000123, 24'h000FFF, 24'h0004FF, 24'h000001};
        logic        cin [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        logic [31:0] exp [4] = '{32'h00000123, 32'hFFFFFFFF, 32'hFF000000, 32'h00000004};
        logic        ec  [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        int          sidx = 0;
        int          ridx = 0;
        int          extra = 0;
        logic [31:0] held = '0;
        for (int c = 0; c < 40 && ridx < 4; c++) begin
            @(negedge clk);
            bus.out_ready = (c >= 5);
            if (sidx < 4) drive(src[sidx], ins[sidx], cin[sidx]);
            else bus.in_valid = 1'b0;
            #1;
            if (c == 2) begin
                checks++;
                held = bus.ExtImm;
                if (bus.in_ready !== 1'b0) begin
                    failures++;
                    $display("FAIL bp_full_ready: got %b want 0", bus.in_ready);
                end
            end
            if (c == 3 || c == 4) begin
                checks++;
                if (bus.out_valid !== 1'b1 || bus.ExtImm !== held || bus.in_ready !== 1'b0) begin
                    failures++;
                    $display("FAIL bp_stall_stable: got v=%b imm=%h rdy=%b want v=1 imm=%h rdy=0",
                             bus.out_valid, bus.ExtImm, bus.in_ready, held);
                end
            end
            if (bus.in_valid && bus.in_ready) sidx++;
            if (bus.out_valid && bus.out_ready) begin
                checks++;
                if (bus.ExtImm !== exp[ridx] || bus.out_carry !== ec[ridx]) begin
                    failures++;
                    $display("FAIL bp_order_%0d: got imm=%h c=%b want imm=%h c=%b",
                             ridx, bus.ExtImm, bus.out_carry, exp[ridx], ec[ridx]);
                end
                ridx++;
            end
        end
        checks++;
        if (ridx != 4) begin
            failures++;
            $display("FAIL bp_timeout: got %0d results want 4", ridx);
        end
        bus.in_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            if (bus.out_valid === 1'b1) extra++;
        end
        checks++;
        if (extra != 0) begin
            failures++;
            $display("FAIL bp_duplicate: got %0d extra valid cycles want 0", extra);
        end
    endtask

    task automatic test_flush();
        int leaked = 0;
        // Two ops held in a stalled pipe, flushed with a request pending.
        bus.out_ready = 1'b0;
        @(negedge clk);
        drive(2'd1, 24'h000AAA, 1'b0);
        @(negedge clk);
        drive(2'd1, 24'h000BBB, 1'b0);
        @(negedge clk);
        drive(2'd1, 24'h000CCC, 1'b0);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL flush_full: got v=%b rdy=%b want v=0 rdy=1",
                     bus.out_valid, bus.in_ready);
        end
        // One op in S1 plus a request accepted in the flush cycle.
        @(negedge clk);
        drive(2'd1, 24'h000DDD, 1'b0);
        @(negedge clk);
        drive(2'd1, 24'h000EEE, 1'b0);
        flush = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL flush_accept_ready: got %b want 1", bus.in_ready);
        end
        @(negedge clk);
        flush = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL flush_accept: out_valid got %b want 0", bus.out_valid);
        end
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            #1;
            if (bus.out_valid === 1'b1) leaked++;
        end
        checks++;
        if (leaked != 0) begin
            failures++;
            $display("FAIL flush_leak: got %0d valid cycles want 0", leaked);
        end
        @(negedge clk);
        drive(2'd3, 24'h000F00, 1'b1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (bus.out_valid !== 1'b1 || bus.ExtImm !== 32'hFFFFFF00 || bus.out_carry !== 1'b1) begin
            failures++;
            $display("FAIL flush_recover: got v=%b imm=%h c=%b want v=1 imm=ffffff00 c=1",
                     bus.out_valid, bus.ExtImm, bus.out_carry);
        end
    endtask

    task automatic test_reset_mid();
        bus.out_ready = 1'b1;
        @(negedge clk);
        drive(2'd0, 24'h0004FF, 1'b0);
        @(negedge clk);
        drive(2'd0, 24'h0004FF, 1'b0);
        @(negedge clk);
        drive(2'd0, 24'h0004FF, 1'b0);
        #1;
        checks++;
        if (bus.out_valid !== 1'b1 || bus.ExtImm !== 32'hFF000000) begin
            failures++;
            $display("FAIL rmid_pre: got v=%b imm=%h want v=1 imm=ff000000",
                     bus.out_valid, bus.ExtImm);
        end
        #1;
        reset_n = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.ExtImm !== 32'h0 || bus.out_carry !== 1'b0) begin
            failures++;
            $display("FAIL rmid_async: got v=%b imm=%h c=%b want v=0 imm=0 c=0",
                     bus.out_valid, bus.ExtImm, bus.out_carry);
        end
        bus.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL rmid_release: got rdy=%b v=%b want rdy=1 v=0",
                     bus.in_ready, bus.out_valid);
        end
        @(negedge clk);
        drive(2'd2, 24'hFFFFFE, 1'b1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL rmid_early: out_valid got %b want 0", bus.out_valid);
        end
        @(negedge clk);
        #1;
        checks++;
        if (bus.out_valid !== 1'b1 || bus.ExtImm !== 32'hFFFFFFF8 || bus.out_carry !== 1'b1) begin
            failures++;
            $display("FAIL rmid_first: got v=%b imm=%h c=%b want v=1 imm=fffffff8 c=1",
                     bus.out_valid, bus.ExtImm, bus.out_carry);
        end
    endtask

    initial begin
        test_reset();
        test_formats();
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
